regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Sequencing controller in front of the RISCV32 register file. It accepts operand-fetch requests (rs1, rs2) from decode and write requests from writeback. It serialises them onto the register file's single read port and single write port using the four-phase `re`/`rack` and `we`/`wack` handshakes, and returns both operands with one completion pulse. It also filters x0 accesses and recovers from a missing acknowledge via a timeout.

## Interface
- `REG_SZ`, 32, register data width.
- `TIMEOUT`, 15, maximum cycles spent waiting for any single ack edge; legal range 2–255.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rd_req` in 1: operand fetch request, held until `rd_done`.
- `rs1`, `rs2` in 5 each: source indices, stable while `rd_req`.
- `op1`, `op2` out REG_SZ: fetched operands, held until the next `rd_done`.
- `rd_done` out 1: one-cycle completion pulse for the read.
- `wr_req` in 1: write request, held until `wr_done`.
- `wr_idx` in 5: destination index, stable while `wr_req`.
- `wr_data` in REG_SZ: write data, stable while `wr_req`.
- `wr_done` out 1: one-cycle completion pulse for the write.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err` out 1: one-cycle pulse on a handshake timeout.
- `rf_re`, `rf_we` out 1: register file read and write strobes.
- `rf_r_idx`, `rf_w_idx` out 5: register file indices.
- `rf_din` out REG_SZ: register file write data.
- `rf_rack`, `rf_wack` in 1: register file acknowledges, level-sampled on `clk`.
- `rf_dout` in REG_SZ: register file read data.

## Operation
- **Reset.** All outputs are 0, the FSM is in IDLE, the timer is 0, and the operand select is 0.
- **States.** IDLE, WR_ASSERT, WR_RELEASE, RD_ASSERT, RD_RELEASE.
- **IDLE arbitration.** `wr_req` has fixed priority over `rd_req`, so writeback lands before operand reads and RAW order is preserved. The request's indices and data are latched on acceptance. Both requests high in the same cycle → the write is served first; the read is accepted in the first IDLE cycle after `wr_done`.
- **Re-acceptance guard.** A request is not accepted in the cycle its own done pulse is high. The requester drops it on that edge; if it is still high on the following edge, it is a new request.
- **Write path.**
  - `wr_idx`=0 → no handshake; `wr_done` pulses on the next cycle.
  - Otherwise: drive `rf_w_idx`/`rf_din` and set `rf_we`=1 (WR_ASSERT).
  - On `rf_wack`=1 → clear `rf_we` (WR_RELEASE).
  - On `rf_wack`=0 → return to IDLE and pulse `wr_done`.
- **Read path.** The operand select starts at rs1.
  - Index 0 → the operand is 0 with no handshake, and the FSM advances immediately, in the same cycle.
  - Otherwise: drive `rf_r_idx` and set `rf_re`=1 (RD_ASSERT).
  - On `rf_rack`=1 → capture `rf_dout` into the selected operand and clear `rf_re` (RD_RELEASE).
  - On `rf_rack`=0 → move to rs2, or, if rs2 is already done, return to IDLE and pulse `rd_done`.
- **Operand outputs.** `op1`/`op2` update only on the `rd_done` cycle; staging registers hold them until then.
- **Timeout.**
  - The timer clears on entry to each ASSERT/RELEASE state and increments every cycle the expected ack level is absent.
  - At count = `TIMEOUT`: drop `rf_re`/`rf_we`, pulse `err` together with the pending done pulse, and return to IDLE.
  - Operands not yet captured are reported as 0.
- **Reset mid-operation.** Strobes drop immediately (asynchronously) and the in-flight request is lost. A request still high after reset release is accepted as new.

## Timing
Edge 0 is the acceptance edge.
- **Nonzero write.** `rf_we` is high after edge 0; `rf_wack` is seen at edge 1 and `rf_we` clears. Release is seen at edge 2; `wr_done` is high in the cycle after edge 2.
- **Two nonzero operands.**
  - `rf_re` high from edge 0.
  - Edge 1: capture `op1`, drop `rf_re`.
  - Edge 2: set rs2 index, raise `rf_re`.
  - Edge 3: capture `op2`.
  - Edge 4: enter IDLE; `rd_done` is high in the cycle after edge 4.
- **One zero operand.** 2-cycle read latency.
- **Both operands zero.** `rd_done` in the cycle after edge 0.
- **Handshake discipline.** `rf_r_idx`, `rf_w_idx` and `rf_din` are stable from the strobe rise until the ack falls. `rf_re` and `rf_we` are never high in the same cycle.
- **Slow register file.** Each extra ack cycle adds exactly one cycle of latency.

## Structure
- **Shared package `riscv32_rf_pkg`.** Holds the FSM state enum, the `REG_IDX_W`=5 constant and the `X0_IDX`=0 constant.
- **Sub-module `rf_hs_port`.** A four-phase strobe/ack engine with its own timeout counter, exposing start, done and timeout. It is instantiated once for the read port and once for the write port. The top-level FSM handles arbitration, operand sequencing and the x0 bypass.

## Test plan
- Reset pulsed in WR_ASSERT → `rf_we`=0 with no clock edge; all outputs 0; state IDLE.
- Write x5=0xDEADBEEF with the register file acking in 1 cycle → `rf_we` high for 1 cycle; `wr_done` in the cycle after edge 2; a subsequent read of x5 returns 0xDEADBEEF.
- Read rs1=3 (value 7) and rs2=4 (value 9) → `op1`=7, `op2`=9; `rd_done` in the cycle after edge 4; `busy` high from the cycle after edge 0 through edge 4.
- Read rs1=0, rs2=0 → `op1`=`op2`=0; no `rf_re` activity; `rd_done` in the cycle after edge 0. Write to x0 → no `rf_we`; `wr_done` on the next cycle.
- `wr_req` and `rd_req` rise together with `wr_idx`=`rs1`=6 and `wr_data`=0x55 → write completes first; `op1`=0x55.
- `rf_rack` stuck at 0 with `TIMEOUT`=15 → after 15 wait cycles, `err` and `rd_done` pulse together; operands are 0; `rf_re`=0; the next request is served normally.

Source files
------------

// File: rtl/riscv32_rf_pkg.sv
// Shared definitions for the RISCV32 register-file sequencing controller.
// Holds the controller FSM state encoding, the handshake-engine phase
// encoding, register index constants and a small x0 test helper.
package riscv32_rf_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0_IDX = 5'd0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_ASSERT  = 3'd1,
    ST_WR_RELEASE = 3'd2,
    ST_RD_ASSERT  = 3'd3,
    ST_RD_RELEASE = 3'd4
  } rf_state_e;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_ASSERT  = 2'd1,
    HS_RELEASE = 2'd2
  } hs_phase_e;

  // x0 is hardwired to zero, so accesses to it never touch the register file.
  function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
    return (idx == X0_IDX);
  endfunction

endpackage

// File: rtl/rf_hs_port.sv
// Four-phase strobe/ack engine for one register-file port.
// i_start raises the strobe; the ack rise drops it; the ack fall completes.
// A per-phase timer gives up after TIMEOUT cycles without the expected ack
// level. Event outputs are combinational so the owning FSM reacts on the
// same clock edge the engine does.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   i_start      - begin a handshake (overrides any phase)
//   i_ack        - acknowledge from the register file, level-sampled
//   o_strobe     - registered strobe to the register file
//   o_ack_seen   - ack rise observed this cycle (capture point for read data)
//   o_done       - ack fall observed this cycle (handshake complete)
//   o_timeout    - expected ack level missing for TIMEOUT cycles
module rf_hs_port
  import riscv32_rf_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_ack,
  output logic o_strobe,
  output logic o_ack_seen,
  output logic o_done,
  output logic o_timeout
);

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  hs_phase_e  r_phase;
  logic       r_strobe;
  logic [7:0] r_timer;

  logic w_ack_seen;
  logic w_done;
  logic w_wait;
  logic w_timeout;

  // Decode this cycle's handshake event from the phase and the ack level.
  always_comb begin
    w_ack_seen = 1'b0;
    w_done     = 1'b0;
    w_wait     = 1'b0;
    case (r_phase)
      HS_ASSERT: begin
        w_ack_seen = i_ack;
        w_wait     = ~i_ack;
      end
      HS_RELEASE: begin
        w_done = ~i_ack;
        w_wait = i_ack;
      end
      default: begin
        w_wait = 1'b0;
      end
    endcase
    // The current wait cycle is the TIMEOUT-th one when the timer already
    // holds TIMEOUT-1, so the engine gives up on this edge.
    w_timeout = w_wait && (r_timer == TIMEOUT_M1);
  end

  // Phase, strobe and per-phase timer; the timer restarts on every phase entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= HS_IDLE;
      r_strobe <= 1'b0;
      r_timer  <= 8'd0;
    end else if (i_start) begin
      r_phase  <= HS_ASSERT;
      r_strobe <= 1'b1;
      r_timer  <= 8'd0;
    end else if (w_ack_seen) begin
      r_phase  <= HS_RELEASE;
      r_strobe <= 1'b0;
      r_timer  <= 8'd0;
    end else if (w_done || w_timeout) begin
      r_phase  <= HS_IDLE;
      r_strobe <= 1'b0;
      r_timer  <= 8'd0;
    end else if (w_wait) begin
      r_timer <= r_timer + 8'd1;
    end else begin
      r_timer <= r_timer;
    end
  end

  assign o_strobe   = r_strobe;
  assign o_ack_seen = w_ack_seen;
  assign o_done     = w_done;
  assign o_timeout  = w_timeout;

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencing controller in front of the RISCV32 register file.
// Serialises operand fetches (rs1 then rs2) and writebacks onto the single
// read and single write port, bypasses x0, and recovers from a missing ack.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   rd_req, rs1, rs2            - operand fetch request and source indices
//   op1, op2, rd_done           - operands (held) and completion pulse
//   wr_req, wr_idx, wr_data     - write request, destination and data
//   wr_done                     - write completion pulse
//   busy, err                   - FSM not idle; handshake timeout pulse
//   rf_re, rf_r_idx, rf_rack, rf_dout          - register-file read port
//   rf_we, rf_w_idx, rf_din, rf_wack           - register-file write port
module regfile_ctrl
  import riscv32_rf_pkg::*;
#(
  parameter int unsigned REG_SZ  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [REG_SZ-1:0]    op1,
  output logic [REG_SZ-1:0]    op2,
  output logic                 rd_done,
  input  logic                 wr_req,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [REG_SZ-1:0]    wr_data,
  output logic                 wr_done,
  output logic                 busy,
  output logic                 err,
  output logic                 rf_re,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_r_idx,
  output logic [REG_IDX_W-1:0] rf_w_idx,
  output logic [REG_SZ-1:0]    rf_din,
  input  logic                 rf_rack,
  input  logic                 rf_wack,
  input  logic [REG_SZ-1:0]    rf_dout
);

  rf_state_e            r_state;
  logic                 r_sel;        // 0: fetching rs1, 1: fetching rs2
  logic [REG_IDX_W-1:0] r_rs2_idx;
  logic [REG_SZ-1:0]    r_stage1;
  logic [REG_SZ-1:0]    r_stage2;
  logic [REG_SZ-1:0]    r_op1;
  logic [REG_SZ-1:0]    r_op2;
  logic                 r_rd_done;
  logic                 r_wr_done;
  logic                 r_err;
  logic [REG_IDX_W-1:0] r_rf_r_idx;
  logic [REG_IDX_W-1:0] r_rf_w_idx;
  logic [REG_SZ-1:0]    r_rf_din;

  logic w_wr_accept, w_rd_accept, w_wr_start, w_rd_start, w_rd_next;
  logic w_rd_strobe, w_rd_ack, w_rd_done, w_rd_to;
  logic w_wr_strobe, w_wr_ack, w_wr_done, w_wr_to;

  // Arbitration and handshake start requests. Writes win in IDLE; a request
  // whose own done pulse is high this cycle is the old one and is ignored.
  always_comb begin
    w_wr_accept = (r_state == ST_IDLE) && wr_req && !r_wr_done;
    w_rd_accept = (r_state == ST_IDLE) && !w_wr_accept && rd_req && !r_rd_done;
    w_wr_start  = w_wr_accept && !is_x0(wr_idx);
    // rs1 released: go straight on to rs2 unless it is x0.
    w_rd_next   = (r_state == ST_RD_RELEASE) && w_rd_done && !r_sel && !is_x0(r_rs2_idx);
    w_rd_start  = (w_rd_accept && !(is_x0(rs1) && is_x0(rs2))) || w_rd_next;
  end

  rf_hs_port #(.TIMEOUT(TIMEOUT)) u_rd_port (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_rd_start),
    .i_ack      (rf_rack),
    .o_strobe   (w_rd_strobe),
    .o_ack_seen (w_rd_ack),
    .o_done     (w_rd_done),
    .o_timeout  (w_rd_to)
  );

  rf_hs_port #(.TIMEOUT(TIMEOUT)) u_wr_port (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_wr_start),
    .i_ack      (rf_wack),
    .o_strobe   (w_wr_strobe),
    .o_ack_seen (w_wr_ack),
    .o_done     (w_wr_done),
    .o_timeout  (w_wr_to)
  );

  // Controller FSM: arbitration, operand sequencing, x0 bypass, completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= 1'b0;
      r_rs2_idx  <= X0_IDX;
      r_stage1   <= '0;
      r_stage2   <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_rd_done  <= 1'b0;
      r_wr_done  <= 1'b0;
      r_err      <= 1'b0;
      r_rf_r_idx <= X0_IDX;
      r_rf_w_idx <= X0_IDX;
      r_rf_din   <= '0;
    end else begin
      r_rd_done <= 1'b0;
      r_wr_done <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_accept) begin
            if (w_wr_start) begin
              r_rf_w_idx <= wr_idx;
              r_rf_din   <= wr_data;
              r_state    <= ST_WR_ASSERT;
            end else begin
              r_wr_done <= 1'b1;
            end
          end else if (w_rd_accept) begin
            // Clear staging so an operand lost to a timeout reads as 0.
            r_stage1  <= '0;
            r_stage2  <= '0;
            r_rs2_idx <= rs2;
            if (!is_x0(rs1)) begin
              r_sel      <= 1'b0;
              r_rf_r_idx <= rs1;
              r_state    <= ST_RD_ASSERT;
            end else if (!is_x0(rs2)) begin
              r_sel      <= 1'b1;
              r_rf_r_idx <= rs2;
              r_state    <= ST_RD_ASSERT;
            end else begin
              r_op1     <= '0;
              r_op2     <= '0;
              r_rd_done <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WR_ASSERT: begin
          if (w_wr_ack) begin
            r_state <= ST_WR_RELEASE;
          end else if (w_wr_to) begin
            r_wr_done <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_WR_ASSERT;
          end
        end
        ST_WR_RELEASE: begin
          if (w_wr_done || w_wr_to) begin
            r_wr_done <= 1'b1;
            r_err     <= w_wr_to;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_WR_RELEASE;
          end
        end
        ST_RD_ASSERT: begin
          if (w_rd_ack) begin
            if (r_sel) begin
              r_stage2 <= rf_dout;
            end else begin
              r_stage1 <= rf_dout;
            end
            r_state <= ST_RD_RELEASE;
          end else if (w_rd_to) begin
            r_op1     <= r_stage1;
            r_op2     <= r_stage2;
            r_rd_done <= 1'b1;
            r_err     <= 1'b1;
            r_sel     <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_RD_ASSERT;
          end
        end
        ST_RD_RELEASE: begin
          if (w_rd_next) begin
            r_sel      <= 1'b1;
            r_rf_r_idx <= r_rs2_idx;
            r_state    <= ST_RD_ASSERT;
          end else if (w_rd_done || w_rd_to) begin
            r_op1     <= r_stage1;
            r_op2     <= r_stage2;
            r_rd_done <= 1'b1;
            r_err     <= w_rd_to;
            r_sel     <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_RD_RELEASE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign op1      = r_op1;
  assign op2      = r_op2;
  assign rd_done  = r_rd_done;
  assign wr_done  = r_wr_done;
  assign err      = r_err;
  assign busy     = (r_state != ST_IDLE);
  assign rf_re    = w_rd_strobe;
  assign rf_we    = w_wr_strobe;
  assign rf_r_idx = r_rf_r_idx;
  assign rf_w_idx = r_rf_w_idx;
  assign rf_din   = r_rf_din;

endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [4:0]  rs1, rs2, wr_idx;
  logic [31:0] wr_data;
  logic [31:0] op1, op2, rf_din, rf_dout;
  logic        rd_done, wr_done, busy, err, rf_re, rf_we;
  logic [4:0]  rf_r_idx, rf_w_idx;
  logic        rf_rack, rf_wack;

  regfile_ctrl #(.REG_SZ(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rs1(rs1), .rs2(rs2), .op1(op1), .op2(op2), .rd_done(rd_done),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_done(wr_done),
    .busy(busy), .err(err),
    .rf_re(rf_re), .rf_we(rf_we), .rf_r_idx(rf_r_idx), .rf_w_idx(rf_w_idx),
    .rf_din(rf_din), .rf_rack(rf_rack), .rf_wack(rf_wack), .rf_dout(rf_dout)
  );

  always #5 clk = ~clk;

  // Register file model: acks on the falling edge after ack_delay extra cycles.
  logic [31:0] mem [32];
  int ack_delay = 0;
  int r_cnt = 0, w_cnt = 0;
  int re_cycles = 0, we_cycles = 0, overlap = 0;

  always @(negedge clk) begin
    if (rf_re && rf_we) overlap++;
    if (rf_re) begin
      re_cycles++;
      if (!rf_rack) begin
        if (r_cnt >= ack_delay) begin
          rf_dout = mem[rf_r_idx];
          rf_rack = 1'b1;
          r_cnt = 0;
        end else begin
          r_cnt++;
        end
      end
    end else begin
      rf_rack = 1'b0;
      r_cnt = 0;
    end
    if (rf_we) begin
      we_cycles++;
      if (!rf_wack) begin
        if (w_cnt >= ack_delay) begin
          mem[rf_w_idx] = rf_din;
          rf_wack = 1'b1;
          w_cnt = 0;
        end else begin
          w_cnt++;
        end
      end
    end else begin
      rf_wack = 1'b0;
      w_cnt = 0;
    end
  end

  typedef struct {
    bit          is_wr;
    logic [31:0] op1;
    logic [31:0] op2;
    int          lat;
    bit          err;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  logic [63:0] busy_hist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the sample just after the acceptance edge; -1 means no done seen.
  task automatic wait_done(input bit is_wr, output int lat, output bit other_seen);
    lat = -1;
    other_seen = 1'b0;
    busy_hist = '0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk); #1;
      busy_hist[c] = busy;
      if (is_wr ? rd_done : wr_done) other_seen = 1'b1;
      if (is_wr ? wr_done : rd_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input int elat, input bit eerr, input string tag);
    exp_t e;
    int   lat;
    bit   other;
    @(posedge clk); #1;
    sb_q.push_back('{is_wr: 1'b0, op1: e1, op2: e2, lat: elat, err: eerr});
    rs1 = a; rs2 = b; rd_req = 1'b1;
    wait_done(1'b0, lat, other);
    rd_req = 1'b0;
    e = sb_q.pop_front();
    check({tag, "_op1"}, op1, e.op1);
    check({tag, "_op2"}, op2, e.op2);
    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
    check({tag, "_err"}, 32'(err), 32'(e.err));
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] d,
                          input int elat, input string tag);
    exp_t e;
    int   lat;
    bit   other;
    @(posedge clk); #1;
    sb_q.push_back('{is_wr: 1'b1, op1: 32'd0, op2: 32'd0, lat: elat, err: 1'b0});
    wr_idx = idx; wr_data = d; wr_req = 1'b1;
    wait_done(1'b1, lat, other);
    wr_req = 1'b0;
    e = sb_q.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
    check({tag, "_err"}, 32'(err), 32'(e.err));
  endtask

  initial begin
    exp_t e;
    int   lat;
    bit   other;
    int   c0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[3] = 32'd7;
    mem[4] = 32'd9;
    rf_rack = 1'b0; rf_wack = 1'b0; rf_dout = 32'd0;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; wr_idx = 5'd0; wr_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 32'({rf_we, rf_re, busy, err, rd_done, wr_done}), 32'd0);
    check("reset_ops", op1 | op2 | rf_din, 32'd0);
    rst = 1'b0;

    // Two nonzero operands: 4-cycle latency, busy through edge 4.
    c0 = re_cycles;
    do_read(5'd3, 5'd4, 32'd7, 32'd9, 4, 1'b0, "rd34");
    check("rd34_busy", 32'(busy_hist[4:0]), 32'h0F);
    check("rd34_re_cycles", 32'(re_cycles - c0), 32'd2);

    // Nonzero write then read it back.
    c0 = we_cycles;
    do_write(5'd5, 32'hDEADBEEF, 2, "wr5");
    check("wr5_we_cycles", 32'(we_cycles - c0), 32'd1);
    do_read(5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2, 1'b0, "rd50");

    // x0 bypass on both paths.
    c0 = re_cycles;
    do_read(5'd0, 5'd0, 32'd0, 32'd0, 0, 1'b0, "rd00");
    check("rd00_re_cycles", 32'(re_cycles - c0), 32'd0);
    c0 = we_cycles;
    do_write(5'd0, 32'hFFFF_FFFF, 0, "wr0");
    check("wr0_we_cycles", 32'(we_cycles - c0), 32'd0);
    do_read(5'd0, 5'd4, 32'd0, 32'd9, 2, 1'b0, "rd04");

    // Simultaneous write and read of x6: write first, read sees new data.
    @(posedge clk); #1;
    sb_q.push_back('{is_wr: 1'b1, op1: 32'd0, op2: 32'd0, lat: 2, err: 1'b0});
    sb_q.push_back('{is_wr: 1'b0, op1: 32'h55, op2: 32'd0, lat: -1, err: 1'b0});
    wr_idx = 5'd6; wr_data = 32'h55; rs1 = 5'd6; rs2 = 5'd0;
    wr_req = 1'b1; rd_req = 1'b1;
    wait_done(1'b1, lat, other);
    wr_req = 1'b0;
    e = sb_q.pop_front();
    check("both_kind_wr", 32'(e.is_wr), 32'd1);
    check("both_wr_lat", 32'(lat), 32'(e.lat));
    check("both_rd_before_wr", 32'(other), 32'd0);
    wait_done(1'b0, lat, other);
    rd_req = 1'b0;
    e = sb_q.pop_front();
    check("both_rd_seen", 32'(lat >= 0), 32'd1);
    check("both_op1", op1, e.op1);
    check("both_op2", op2, e.op2);

    // Slow register file: two extra cycles per ack rise.
    ack_delay = 2;
    do_read(5'd3, 5'd4, 32'd7, 32'd9, 8, 1'b0, "slow");

    // Stuck read ack: timeout after 15 wait cycles, operands reported as 0.
    ack_delay = 1000;
    do_read(5'd3, 5'd4, 32'd0, 32'd0, 15, 1'b1, "tmo");
    check("tmo_re_low", 32'(rf_re), 32'd0);
    ack_delay = 0;
    do_read(5'd3, 5'd4, 32'd7, 32'd9, 4, 1'b0, "after_tmo");

    // Asynchronous reset while a write sits in WR_ASSERT.
    ack_delay = 1000;
    @(posedge clk); #1;
    wr_idx = 5'd5; wr_data = 32'h1234; wr_req = 1'b1;
    @(posedge clk); #1;
    check("mid_we_high", 32'(rf_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ctl", 32'({rf_we, rf_re, busy, err, rd_done, wr_done}), 32'd0);
    check("mid_rst_idx", 32'({rf_r_idx, rf_w_idx}), 32'd0);
    check("mid_rst_data", op1 | op2 | rf_din, 32'd0);
    wr_req = 1'b0;
    ack_delay = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(5'd5, 5'd3, 32'hDEADBEEF, 32'd7, 4, 1'b0, "post_rst");

    check("strobe_overlap", 32'(overlap), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
